// File: rtl/spi_sample_sequencer.sv
// spi_sample_sequencer: a programmable sample-rate timer starts one SPI read
// frame per tick (CS_b low, DATA_W sclk periods, MISO shifted in MSB first),
// then offers the captured word on a valid/ready push port. Ticks that arrive
// while a frame or push is still pending are dropped and counted (saturating).
module spi_sample_sequencer #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16,
  parameter int HALF_W = 8,
  parameter int OVR_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              enable,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [HALF_W-1:0] sclk_half_div,
  input  logic              clear_overrun,
  input  logic              MISO,
  output logic              CS_b,
  output logic              sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun_count
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = {OVR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PUSH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] h_q, h_d;
  logic [HALF_W-1:0] hcnt_q, hcnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cs_b_q, cs_b_d;
  logic              sclk_q, sclk_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              tick_s;
  logic              overrun_s;
  logic              half_done_s;

  // Sample-rate timer and dropped-tick counter
  always_comb begin
    tick_s = 1'b0;
    cnt_d  = cnt_q;
    if (enable) begin
      // >= so that lowering sample_div below the running count ticks at once
      if (cnt_q >= sample_div) begin
        tick_s = 1'b1;
        cnt_d  = {DIV_W{1'b0}};
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = {DIV_W{1'b0}};
    end

    overrun_s = tick_s && (state_q != ST_IDLE);

    // A clear that coincides with a drop must still record that drop
    if (clear_overrun) begin
      ovr_d = overrun_s ? OVR_W'(1) : {OVR_W{1'b0}};
    end else if (overrun_s && (ovr_q != OVR_MAX)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Frame sequencer: next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    hcnt_d      = hcnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    cs_b_d      = cs_b_q;
    sclk_d      = sclk_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    half_done_s = (hcnt_q == (h_q - HALF_W'(1)));

    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          // Half period is latched so register writes cannot disturb this frame
          h_d     = (sclk_half_div == {HALF_W{1'b0}}) ? HALF_W'(1) : sclk_half_div;
          hcnt_d  = {HALF_W{1'b0}};
          cs_b_d  = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (half_done_s) begin
          hcnt_d  = {HALF_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
          sclk_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          hcnt_d = hcnt_q + HALF_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!half_done_s) begin
          hcnt_d = hcnt_q + HALF_W'(1);
        end else if (!sclk_q) begin
          // End of low phase: sclk rises on this edge, capture MISO with it
          hcnt_d  = {HALF_W{1'b0}};
          sclk_d  = 1'b1;
          shift_d = {shift_q[DATA_W-2:0], MISO};
        end else if (bit_q == LAST_BIT) begin
          hcnt_d  = {HALF_W{1'b0}};
          state_d = ST_HOLD;
        end else begin
          hcnt_d = {HALF_W{1'b0}};
          bit_d  = bit_q + BIT_W'(1);
          sclk_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (half_done_s) begin
          hcnt_d  = {HALF_W{1'b0}};
          cs_b_d  = 1'b1;
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = ST_PUSH;
        end else begin
          hcnt_d = hcnt_q + HALF_W'(1);
        end
      end
      ST_PUSH: begin
        if (valid_q && sample_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_b_d  = 1'b1;
        sclk_d  = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {DIV_W{1'b0}};
      h_q     <= HALF_W'(1);
      hcnt_q  <= {HALF_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      shift_q <= {DATA_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= {OVR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CS_b          = cs_b_q;
  assign sclk          = sclk_q;
  assign sample_data   = data_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed bench for spi_sample_sequencer: an ADC model serialises a chosen
// word on MISO (bit changes after each sclk rise); each task drives one
// scenario and compares against hand-computed cycle counts and words.
module tb_spi_sample_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_div = 16'd99;
  logic [7:0]  sclk_half_div = 8'd2;
  logic        clear_overrun = 1'b0;
  logic        MISO = 1'b0;
  logic        CS_b;
  logic        sclk;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic [7:0]  overrun_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] miso_word = 16'h0000;
  int          rise_cnt = 0;
  logic        sclk_prev = 1'b1;

  spi_sample_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .sample_div(sample_div),
    .sclk_half_div(sclk_half_div), .clear_overrun(clear_overrun), .MISO(MISO),
    .CS_b(CS_b), .sclk(sclk), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun_count(overrun_count)
  );

  always #5 PCLK = ~PCLK;

  // ADC model: count sclk rises within a frame and present the next bit
  always @(negedge PCLK) begin
    int idx;
    if (CS_b === 1'b1) rise_cnt = 0;
    else if (sclk === 1'b1 && sclk_prev === 1'b0) rise_cnt = rise_cnt + 1;
    sclk_prev = sclk;
    if (rise_cnt < 16) begin
      idx  = 15 - rise_cnt;
      MISO = miso_word[idx];
    end else begin
      MISO = 1'b0;
    end
  end

  task automatic step();
    @(negedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    step();
    total++; if (CS_b !== 1'b1) begin bad++; $display("FAIL reset_csb: got %b want 1", CS_b); end
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    total++; if (sample_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", sample_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL reset_ovr: got %0d want 0", overrun_count); end
    PRESETn = 1'b1;
    step();
  endtask

  // Scenario 1: H=2, div=99, word A5C3
  task automatic test_basic();
    int n; int low; int sl; int rises; int m;
    miso_word = 16'hA5C3; sample_div = 16'd99; sclk_half_div = 8'd2; sample_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (CS_b !== 1'b0 && n < 300);
    total++; if (n != 100) begin bad++; $display("FAIL basic_first_tick: got %0d want 100", n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    low = 0; sl = 0; rises = 0;
    while (CS_b === 1'b0 && low < 200) begin
      low++; if (sclk === 1'b0) sl++; rises = rise_cnt;
      step();
    end
    total++; if (low != 68) begin bad++; $display("FAIL basic_cs_low: got %0d want 68", low); end
    total++; if (sl != 32) begin bad++; $display("FAIL basic_sclk_low: got %0d want 32", sl); end
    total++; if (rises != 16) begin bad++; $display("FAIL basic_rises: got %0d want 16", rises); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency: got %b want 1", sample_valid); end
    total++; if (sample_data !== 16'hA5C3) begin bad++; $display("FAIL basic_data: got %h want a5c3", sample_data); end
    step();
    m = 69;
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", sample_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", busy); end
    while (CS_b !== 1'b0 && m < 300) begin step(); m++; end
    total++; if (m != 100) begin bad++; $display("FAIL basic_period: got %0d want 100", m); end
    n = 0;
    while (sample_valid !== 1'b1 && n < 200) begin step(); n++; end
    total++; if (sample_data !== 16'hA5C3 || sample_valid !== 1'b1) begin bad++; $display("FAIL basic_data2: got %h/%b want a5c3/1", sample_data, sample_valid); end
    step();
  endtask

  // Scenario 2: backpressure for 300 cycles
  task automatic test_backpressure();
    int n; logic held_ok;
    sample_ready = 1'b0; miso_word = 16'h3C5A;
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    n = 0;
    while (sample_valid !== 1'b1 && n < 300) begin step(); n++; end
    total++; if (sample_data !== 16'h3C5A) begin bad++; $display("FAIL bp_data: got %h want 3c5a", sample_data); end
    held_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (sample_valid !== 1'b1 || sample_data !== 16'h3C5A || CS_b !== 1'b1) held_ok = 1'b0;
    end
    total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL bp_held: got %b want 1", held_ok); end
    total++; if (overrun_count !== 8'd3) begin bad++; $display("FAIL bp_overrun: got %0d want 3", overrun_count); end
    sample_ready = 1'b1;
    step();
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", sample_valid); end
  endtask

  // Scenario 3: saturation and clear-with-overrun
  task automatic test_overrun_sat();
    int n;
    sample_ready = 1'b0; sample_div = 16'd0;
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    n = 0;
    while (overrun_count !== 8'd255 && n < 2000) begin step(); n++; end
    total++; if (n >= 2000) begin bad++; $display("FAIL sat_reach: got %0d want 255", overrun_count); end
    for (int i = 0; i < 20; i++) step();
    total++; if (overrun_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", overrun_count); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL sat_in_push: got %b want 1", sample_valid); end
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    total++; if (overrun_count !== 8'd1) begin bad++; $display("FAIL clr_with_ovr: got %0d want 1", overrun_count); end
    step();
    total++; if (overrun_count !== 8'd2) begin bad++; $display("FAIL ovr_after_clr: got %0d want 2", overrun_count); end
    enable = 1'b0; sample_ready = 1'b1;
    step(); step();
    total++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sat_drain: got %b/%b want 0/0", sample_valid, busy); end
    sample_div = 16'd99;
  endtask

  // Scenario 4: enable dropped at bit 5, plus divider writes mid-frame
  task automatic test_enable_drop();
    int n; int low; logic dropped; logic quiet;
    miso_word = 16'h1234; sample_ready = 1'b1; sample_div = 16'd99; sclk_half_div = 8'd2;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (CS_b !== 1'b0 && n < 300);
    low = 0; dropped = 1'b0;
    while (CS_b === 1'b0 && low < 300) begin
      low++;
      if (!dropped && rise_cnt == 5) begin
        enable = 1'b0; sclk_half_div = 8'd5; sample_div = 16'd7; dropped = 1'b1;
      end
      step();
    end
    total++; if (low != 68) begin bad++; $display("FAIL en_cs_low: got %0d want 68", low); end
    total++; if (sample_valid !== 1'b1 || sample_data !== 16'h1234) begin bad++; $display("FAIL en_push: got %b/%h want 1/1234", sample_valid, sample_data); end
    quiet = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (CS_b !== 1'b1 || sample_valid !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL en_quiet: got %b want 1", quiet); end
    sclk_half_div = 8'd2; sample_div = 16'd99;
  endtask

  // Scenario 5: reset at bit 8
  task automatic test_reset_midframe();
    int n; logic quiet;
    miso_word = 16'hFFFF; sample_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!(CS_b === 1'b0 && rise_cnt == 8) && n < 400) begin step(); n++; end
    total++; if (n >= 400) begin bad++; $display("FAIL rst_reach_bit8: got %0d want 8", rise_cnt); end
    PRESETn = 1'b0;
    #1;
    total++; if (CS_b !== 1'b1 || sclk !== 1'b1) begin bad++; $display("FAIL rst_mid_lines: got %b/%b want 1/1", CS_b, sclk); end
    total++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b/%b want 0/0", sample_valid, busy); end
    enable = 1'b0;
    step(); step();
    PRESETn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (CS_b !== 1'b1 || sample_valid !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rst_no_push: got %b want 1", quiet); end
  endtask

  // Scenario 6: sclk_half_div=0 behaves as H=1
  task automatic test_h_zero();
    int n; int low; int sl; int rises;
    miso_word = 16'h8001; sclk_half_div = 8'd0; sample_div = 16'd99; sample_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (CS_b !== 1'b0 && n < 300);
    low = 0; sl = 0; rises = 0;
    while (CS_b === 1'b0 && low < 200) begin
      low++; if (sclk === 1'b0) sl++; rises = rise_cnt;
      step();
    end
    total++; if (low != 34) begin bad++; $display("FAIL h0_cs_low: got %0d want 34", low); end
    total++; if (sl != 16) begin bad++; $display("FAIL h0_sclk_low: got %0d want 16", sl); end
    total++; if (rises != 16) begin bad++; $display("FAIL h0_rises: got %0d want 16", rises); end
    total++; if (sample_valid !== 1'b1 || sample_data !== 16'h8001) begin bad++; $display("FAIL h0_push: got %b/%h want 1/8001", sample_valid, sample_data); end
    enable = 1'b0;
    step();
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL h0_valid_drop: got %b want 0", sample_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun_sat();
    test_enable_drop();
    test_reset_midframe();
    test_h_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
